// File: rtl/ofdm_cp_remover_pkg.sv
// Shared OFDM types and default dimensions for the CP remover and its neighbours.
package ofdm_cp_remover_pkg;

  typedef enum logic [1:0] {
    DISCARD = 2'd0,
    PASS    = 2'd1,
    TAIL    = 2'd2,
    PAD     = 2'd3
  } state_t;

  typedef struct packed {
    logic [15:0] i;
    logic [15:0] q;
  } sample_t;

  localparam int DEF_SYMBOL_LEN      = 64;
  localparam int DEF_CP_LEN          = 16;
  localparam int DEF_CP_ADVANCE      = 4;
  localparam int DEF_MAX_NUM_SYMBOLS = 512;

endpackage

// File: rtl/ofdm_cp_counter.sv
// Symbol-position counter: counts accepted samples 0..TOTAL-1 and wraps at symbol end.
// A frame-last sample anywhere but the final position restarts the count and flags truncation.
module ofdm_cp_counter #(
  parameter int TOTAL = 80,
  parameter int CW    = $clog2(TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_adv,
  input  logic          i_last,
  output logic [CW-1:0] o_cnt,
  output logic          o_wrap,
  output logic          o_trunc
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_adv) begin
      if (i_last || o_wrap) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_cnt   = r_cnt;
  assign o_wrap  = (r_cnt == CW'(TOTAL - 1));
  assign o_trunc = i_last & ~o_wrap;

endmodule

// File: rtl/ofdm_cp_remover.sv
// Strips the cyclic prefix from each OFDM symbol and emits SYMBOL_LEN-sample packets, zero-padding truncated frames.
// One registered output stage (1-cycle latency); input stalls only while retaining samples or padding.
module ofdm_cp_remover
  import ofdm_cp_remover_pkg::*;
#(
  parameter int SYMBOL_LEN      = DEF_SYMBOL_LEN,
  parameter int CP_LEN          = DEF_CP_LEN,
  parameter int CP_ADVANCE      = DEF_CP_ADVANCE,
  parameter int MAX_NUM_SYMBOLS = DEF_MAX_NUM_SYMBOLS
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [31:0]                          i_tdata,
  input  logic                                 i_tlast,
  input  logic                                 i_tvalid,
  output logic                                 i_tready,
  output logic [31:0]                          o_tdata,
  output logic                                 o_tlast,
  output logic                                 o_eof,
  output logic                                 o_tvalid,
  input  logic                                 o_tready,
  output logic [$clog2(MAX_NUM_SYMBOLS+1)-1:0] o_sym_index,
  output logic                                 o_short_frame
);

  localparam int TOTAL    = CP_LEN + SYMBOL_LEN;
  localparam int DISC_LEN = CP_LEN - CP_ADVANCE;
  localparam int CW       = $clog2(TOTAL);
  localparam int PW       = $clog2(SYMBOL_LEN);
  localparam int SW       = $clog2(MAX_NUM_SYMBOLS + 1);

  if (CP_ADVANCE < 0 || CP_ADVANCE >= CP_LEN) begin : g_bad_cp_advance
    $error("ofdm_cp_remover: CP_ADVANCE must lie in 0..CP_LEN-1");
  end

  state_t          r_state;
  state_t          w_state_nxt;
  sample_t         r_tdata;
  logic            r_tvalid;
  logic            r_tlast;
  logic            r_eof;
  logic            r_short;
  logic [PW-1:0]   r_pcnt;
  logic [SW-1:0]   r_sym_index;

  logic            w_ld;
  logic            w_in_rdy;
  logic            w_accept;
  logic [CW-1:0]   w_cnt;
  logic            w_wrap;
  logic            w_trunc;
  logic            w_pass_last;
  logic            w_load;
  logic            w_load_zero;
  logic            w_load_vld;
  logic            w_load_tlast;
  logic            w_load_eof;
  logic            w_reveal;
  logic            w_reveal_eof;
  logic            w_short;

  assign w_ld        = ~r_tvalid | o_tready;
  assign w_accept    = i_tvalid & w_in_rdy;
  assign w_pass_last = (r_pcnt == PW'(SYMBOL_LEN - 1));

  ofdm_cp_counter #(
    .TOTAL (TOTAL),
    .CW    (CW)
  ) u_counter (
    .clk     (clk),
    .reset   (reset),
    .i_adv   (w_accept),
    .i_last  (i_tlast),
    .o_cnt   (w_cnt),
    .o_wrap  (w_wrap),
    .o_trunc (w_trunc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= DISCARD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_in_rdy     = 1'b0;
    w_load       = 1'b0;
    w_load_zero  = 1'b0;
    w_load_vld   = 1'b0;
    w_load_tlast = 1'b0;
    w_load_eof   = 1'b0;
    w_reveal     = 1'b0;
    w_reveal_eof = 1'b0;
    w_short      = 1'b0;
    case (r_state)
      DISCARD: begin
        w_in_rdy = 1'b1;
        if (i_tvalid) begin
          if (w_trunc) begin
            w_state_nxt = PAD;
            w_short     = 1'b1;
          end else if (w_cnt == CW'(DISC_LEN - 1)) begin
            w_state_nxt = PASS;
          end
        end
      end
      PASS: begin
        w_in_rdy = w_ld;
        if (i_tvalid && w_ld) begin
          w_load     = 1'b1;
          w_load_vld = 1'b1;
          if (w_pass_last) begin
            w_load_tlast = 1'b1;
            if (w_wrap || i_tlast) begin
              w_load_eof  = i_tlast;
              w_state_nxt = DISCARD;
            end else begin
              // Frame end is only known once the tail arrives, so the closing sample waits there.
              w_load_vld  = 1'b0;
              w_state_nxt = TAIL;
            end
          end else if (w_trunc) begin
            w_state_nxt = PAD;
            w_short     = 1'b1;
          end
        end
      end
      TAIL: begin
        w_in_rdy = 1'b1;
        if (i_tvalid && (w_wrap || i_tlast)) begin
          w_reveal     = 1'b1;
          w_reveal_eof = i_tlast;
          w_state_nxt  = DISCARD;
        end
      end
      PAD: begin
        if (w_ld) begin
          w_load      = 1'b1;
          w_load_zero = 1'b1;
          w_load_vld  = 1'b1;
          if (w_pass_last) begin
            w_load_tlast = 1'b1;
            w_load_eof   = 1'b1;
            w_state_nxt  = DISCARD;
          end
        end
      end
      default: w_state_nxt = DISCARD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_eof       <= 1'b0;
      r_short     <= 1'b0;
      r_pcnt      <= '0;
      r_sym_index <= '0;
    end else begin
      r_short <= w_short;
      if (w_load) begin
        r_tdata  <= w_load_zero ? '0 : sample_t'(i_tdata);
        r_tvalid <= w_load_vld;
        r_tlast  <= w_load_tlast;
        r_eof    <= w_load_eof;
        r_pcnt   <= w_load_tlast ? '0 : r_pcnt + PW'(1);
      end else if (w_reveal) begin
        r_tvalid <= 1'b1;
        r_eof    <= w_reveal_eof;
      end else if (o_tready) begin
        r_tvalid <= 1'b0;
      end
      // Index advances only once the symbol's last sample has left, so it is stable across the packet.
      if (r_tvalid && o_tready && r_tlast) begin
        r_sym_index <= r_eof ? '0 : r_sym_index + SW'(1);
      end
    end
  end

  assign i_tready      = w_in_rdy;
  assign o_tdata       = r_tdata;
  assign o_tvalid      = r_tvalid;
  assign o_tlast       = r_tlast;
  assign o_eof         = r_eof;
  assign o_sym_index   = r_sym_index;
  assign o_short_frame = r_short;

endmodule

// File: tb/tb_ofdm_cp_remover.sv
// Directed bench for ofdm_cp_remover: two instances (CP_ADVANCE 0 and 4) behind one shared stimulus driver.
module tb_ofdm_cp_remover;

  localparam int SYM = 64;
  localparam int TOT = 80;
  localparam int SW  = $clog2(512 + 1);

  typedef struct packed {
    logic [31:0]   d;
    logic          tl;
    logic          eof;
    logic [SW-1:0] idx;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel;
  logic        rnd;
  logic [31:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        o_tready;

  logic          a_i_tready, a_o_tlast, a_o_eof, a_o_tvalid, a_o_short;
  logic [31:0]   a_o_tdata;
  logic [SW-1:0] a_o_sym_index;
  logic          b_i_tready, b_o_tlast, b_o_eof, b_o_tvalid, b_o_short;
  logic [31:0]   b_o_tdata;
  logic [SW-1:0] b_o_sym_index;

  ofdm_cp_remover #(.SYMBOL_LEN(64), .CP_LEN(16), .CP_ADVANCE(0), .MAX_NUM_SYMBOLS(512)) dut_a (
    .clk(clk), .reset(rst), .i_tdata(i_tdata), .i_tlast(i_tlast),
    .i_tvalid(i_tvalid && !sel), .i_tready(a_i_tready),
    .o_tdata(a_o_tdata), .o_tlast(a_o_tlast), .o_eof(a_o_eof), .o_tvalid(a_o_tvalid),
    .o_tready(o_tready), .o_sym_index(a_o_sym_index), .o_short_frame(a_o_short)
  );

  ofdm_cp_remover #(.SYMBOL_LEN(64), .CP_LEN(16), .CP_ADVANCE(4), .MAX_NUM_SYMBOLS(512)) dut_b (
    .clk(clk), .reset(rst), .i_tdata(i_tdata), .i_tlast(i_tlast),
    .i_tvalid(i_tvalid && sel), .i_tready(b_i_tready),
    .o_tdata(b_o_tdata), .o_tlast(b_o_tlast), .o_eof(b_o_eof), .o_tvalid(b_o_tvalid),
    .o_tready(o_tready), .o_sym_index(b_o_sym_index), .o_short_frame(b_o_short)
  );

  wire          w_i_tready    = sel ? b_i_tready    : a_i_tready;
  wire [31:0]   w_o_tdata     = sel ? b_o_tdata     : a_o_tdata;
  wire          w_o_tlast     = sel ? b_o_tlast     : a_o_tlast;
  wire          w_o_eof       = sel ? b_o_eof       : a_o_eof;
  wire          w_o_tvalid    = sel ? b_o_tvalid    : a_o_tvalid;
  wire [SW-1:0] w_o_sym_index = sel ? b_o_sym_index : a_o_sym_index;
  wire          w_o_short     = sel ? b_o_short     : a_o_short;

  int   errors = 0;
  int   checks = 0;
  int   short_seen = 0;
  int   exp_short = 0;
  bit   abort = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model state: position inside the input symbol and frame symbol number.
  int          m_pos = 0;
  int          m_sym = 0;
  int          cur_disc = 16;
  logic [31:0] m_hold_d = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic tl, input logic eof);
    exp_t e;
    e.d = d; e.tl = tl; e.eof = eof; e.idx = SW'(m_sym);
    exp_q.push_back(e);
  endtask

  task automatic pad_zeros(input int from_idx);
    for (int j = from_idx; j < SYM; j++) push(32'd0, j == SYM - 1, j == SYM - 1);
    exp_short++;
  endtask

  task automatic model_in(input logic [31:0] d, input logic l);
    int ridx;
    if (m_pos >= cur_disc && m_pos < cur_disc + SYM) begin
      ridx = m_pos - cur_disc;
      if (ridx == SYM - 1) begin
        if (m_pos == TOT - 1 || l) push(d, 1'b1, l);
        else m_hold_d = d;
      end else begin
        push(d, 1'b0, 1'b0);
        if (l) pad_zeros(ridx + 1);
      end
    end else if (m_pos < cur_disc) begin
      if (l) pad_zeros(0);
    end else if (m_pos == TOT - 1 || l) begin
      push(m_hold_d, 1'b1, l);
    end
    if (l) begin
      m_pos = 0; m_sym = 0;
    end else if (m_pos == TOT - 1) begin
      m_pos = 0; m_sym++;
    end else begin
      m_pos++;
    end
  endtask

  task automatic set_dut(input bit s);
    sel = s;
    cur_disc = s ? 12 : 16;
    m_pos = 0;
    m_sym = 0;
  endtask

  task automatic send(input int base, input int n, input bit close);
    for (int k = 0; k < n; k++) begin
      int  w;
      bit  acc;
      bit  in_prefix;
      if (abort) break;
      i_tvalid  = 1'b1;
      i_tdata   = 32'(base + k);
      i_tlast   = close && (k == n - 1);
      in_prefix = (m_pos < cur_disc);
      model_in(i_tdata, i_tlast);
      w   = 0;
      acc = 0;
      while (!acc && !abort) begin
        @(negedge clk);
        if (w == 0 && in_prefix) check("rdy_in_discard", 64'(w_i_tready), 64'd1);
        acc = w_i_tready;
        @(posedge clk); #1;
        w++;
        if (!acc && w > 300) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout sample=%0d got=stalled exp=accepted", base + k);
          abort = 1;
        end
      end
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int w = 0;
    while ((exp_q.size() != 0 || w_o_tvalid) && w < 4000) begin
      @(posedge clk); #1;
      w++;
    end
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_short_pulses"}, 64'(short_seen), 64'(exp_short));
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (w_o_short) short_seen++;
      if (w_o_tvalid && o_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $error("FAIL out_unexpected got=%0h exp=none", w_o_tdata);
        end else begin
          mon_e = exp_q.pop_front();
          assert ({w_o_tdata, w_o_tlast, w_o_eof, w_o_sym_index} === mon_e) else begin
            errors++;
            $error("FAIL out_sample got=%0h/tl%0b/eof%0b/idx%0d exp=%0h/tl%0b/eof%0b/idx%0d",
                   w_o_tdata, w_o_tlast, w_o_eof, w_o_sym_index,
                   mon_e.d, mon_e.tl, mon_e.eof, mon_e.idx);
          end
        end
      end
    end
  end

  initial begin
    o_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      o_tready = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; sel = 1'b0; rnd = 1'b0;
    i_tvalid = 1'b0; i_tlast = 1'b0; i_tdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 64'(a_o_tvalid), 64'd0);
    check("rst_tlast", 64'(a_o_tlast), 64'd0);
    check("rst_eof", 64'(a_o_eof), 64'd0);
    check("rst_tdata", 64'(a_o_tdata), 64'd0);
    check("rst_sym_index", 64'(a_o_sym_index), 64'd0);
    check("rst_short", 64'(a_o_short), 64'd0);
    check("rst_b_tvalid", 64'(b_o_tvalid), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full 3-symbol frame, no advance.
    set_dut(0);
    send(0, 240, 1);
    drain("s1_adv0");

    // Same frame with a 4-sample advance.
    set_dut(1);
    send(0, 240, 1);
    drain("s2_adv4");

    // Output backpressure at 30% duty on both instances.
    set_dut(0);
    rnd = 1'b1;
    send(0, 240, 1);
    drain("s3_rand_adv0");
    set_dut(1);
    send(0, 240, 1);
    drain("s3_rand_adv4");
    rnd = 1'b0;

    // Frame ends at input sample 100: symbol 1 retained index 4.
    set_dut(0);
    send(0, 101, 1);
    check("pad_holds_input", 64'(w_i_tready), 64'd0);
    drain("s4_trunc_pass");

    // Frame ends inside symbol 1 prefix.
    send(0, 86, 1);
    drain("s5_trunc_prefix");

    // Asynchronous reset during symbol 1 retention.
    send(2000, 100, 0);
    #1;
    rst = 1'b1;
    #1;
    check("arst_tvalid", 64'(a_o_tvalid), 64'd0);
    check("arst_tlast", 64'(a_o_tlast), 64'd0);
    check("arst_eof", 64'(a_o_eof), 64'd0);
    check("arst_tdata", 64'(a_o_tdata), 64'd0);
    check("arst_sym_index", 64'(a_o_sym_index), 64'd0);
    check("arst_short", 64'(a_o_short), 64'd0);
    check("arst_pending", 64'(exp_q.size()), 64'd1);
    exp_q.delete();
    set_dut(0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(3000, 240, 1);
    drain("s6_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
